luxor_slice: RTL and testbench

Parametrised LUXOR logic slice: NUM_QS quarter-slices, each a 6-input fracturable LUT (O6/O5), carry-chain mux, optional XOR6 and XOR6-carry extensions, and two synchronous storage flops. Configuration is loaded through an on-block word-serial loader with valid/ready handshake, replacing the external bit-serial config clock. The block sits in the fabric tile as the drop-in successor of the single quarter slice, one instance per slice.

---
 rtl/luxor_slice.sv | 169 ++++++++++++++++
 tb/tb_luxor_slice.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/luxor_slice.sv
// luxor_slice: parametrised logic slice of NUM_QS quarter-slices. Each quarter
// has a 6-input fracturable LUT (O6/O5), a carry mux, optional XOR6 and
// XOR6-carry extensions and two synchronous flops. Configuration arrives
// through a word-serial valid/ready loader.
// Ports:
//   clk, GSR                  clock, synchronous active-high reset
//   A[6*NUM_QS]               LUT inputs, A[6q+5:6q] = A6..A1 of quarter q
//   AX, F78MUX [NUM_QS]       bypass / wide-mux inputs
//   CIN, COUT                 carry into q0 / out of last quarter
//   CE, SR                    shared clock enable, synchronous set/reset
//   O6_out, A_out, AMUX, AQ   per-quarter outputs
//   cfg_start, cfg_valid, cfg_data, cfg_ready, cfg_done   config loader
module luxor_slice #(
  parameter int NUM_QS    = 4,
  parameter int XOR6_MODE = 2,
  parameter int CFG_W     = 16
) (
  input  logic                  clk,
  input  logic                  GSR,
  input  logic [6*NUM_QS-1:0]   A,
  input  logic [NUM_QS-1:0]     AX,
  input  logic [NUM_QS-1:0]     F78MUX,
  input  logic                  CIN,
  input  logic                  CE,
  input  logic                  SR,
  output logic [NUM_QS-1:0]     O6_out,
  output logic [NUM_QS-1:0]     A_out,
  output logic [NUM_QS-1:0]     AMUX,
  output logic [NUM_QS-1:0]     AQ,
  output logic                  COUT,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic [CFG_W-1:0]      cfg_data,
  output logic                  cfg_ready,
  output logic                  cfg_done
);
  localparam int QB = 77;
  localparam int NB = NUM_QS * QB;
  localparam int W  = (NB + CFG_W - 1) / CFG_W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  // Only the NB used bits are stored: padding above NB never shifts back
  // into a used position, so dropping it leaves every field unchanged.
  logic [NB-1:0]   cfg, cfg_shift;
  logic            accept, finish;

  logic [NUM_QS-1:0] f1, f2, d1, d2;

  assign cfg_shift = {cfg[NB-CFG_W-1:0], cfg_data};
  // A start in the same cycle as valid restarts the count and drops the word.
  assign accept    = (state == S_LOAD) && cfg_valid && !cfg_start;
  assign finish    = accept && (cnt == CW'(W - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cfg_ready = 1'b0;
    cfg_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_start) begin
          cnt_nxt = '0;
        end else if (accept) begin
          if (finish) state_nxt = S_DONE;
          else        cnt_nxt   = cnt + CW'(1);
        end
      end
      S_DONE: begin
        cfg_done = 1'b1;
        if (cfg_start) begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (GSR) begin
      state <= S_IDLE;
      cnt   <= '0;
      cfg   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) cfg <= cfg_shift;
    end
  end

  // Datapath for all quarters in one process so the carry ripples through a
  // local variable instead of a self-dependent vector.
  logic [5:0]  a;
  logic [63:0] lut;
  logic        o6, o5, x6, cinq, cin_eff, mux1, co, xor2, xor2x, x6_g, xor2x_g;
  logic [2:0]  sel4, sel5;
  logic [7:0]  amux_src, d2_src;

  always_comb begin
    a = '0; lut = '0; o6 = 1'b0; o5 = 1'b0; x6 = 1'b0; cin_eff = 1'b0;
    mux1 = 1'b0; co = 1'b0; xor2 = 1'b0; xor2x = 1'b0; x6_g = 1'b0;
    xor2x_g = 1'b0; sel4 = '0; sel5 = '0; amux_src = '0; d2_src = '0;
    O6_out = '0; AMUX = '0; d1 = '0; d2 = '0;
    cinq = CIN;
    for (int unsigned q = 0; q < NUM_QS; q++) begin
      a    = A[6*q +: 6];
      lut  = cfg[q*QB +: 64];
      o6   = lut[a];
      o5   = lut[{1'b0, a[4:0]}];
      x6   = ^a;
      sel4 = cfg[q*QB+70 +: 3];
      sel5 = cfg[q*QB+73 +: 3];
      if (XOR6_MODE == 2 && cfg[q*QB+76]) cin_eff = x6 ? cinq : a[0];
      else                                cin_eff = cinq;
      mux1    = cfg[q*QB+68] ? o5 : AX[q];
      co      = o6 ? cin_eff : mux1;
      xor2    = o6 ^ cin_eff;
      xor2x   = x6 ^ cinq;
      x6_g    = (XOR6_MODE >= 1) ? x6 : 1'b0;
      xor2x_g = (XOR6_MODE >= 2) ? xor2x : 1'b0;
      amux_src = {xor2x_g, x6_g, o6, o5, xor2, F78MUX[q], co, f1[q]};
      d2_src   = {xor2x_g, x6_g, co, F78MUX[q], xor2, AX[q], o5, o6};
      O6_out[q] = o6;
      AMUX[q]   = amux_src[sel4];
      d1[q]     = cfg[q*QB+69] ? o5 : AX[q];
      d2[q]     = d2_src[sel5];
      cinq      = co;
    end
    COUT = cinq;
  end

  assign A_out = O6_out;
  assign AQ    = f2;

  // INIT is taken from the word being accepted so it appears together with
  // cfg_done; this overrides the freeze that otherwise holds during LOAD.
  always_ff @(posedge clk) begin
    if (GSR) begin
      f1 <= '0;
      f2 <= '0;
    end else begin
      for (int unsigned q = 0; q < NUM_QS; q++) begin
        if (finish) begin
          f1[q] <= cfg_shift[q*QB+64];
          f2[q] <= cfg_shift[q*QB+65];
        end else if (state != S_LOAD) begin
          if (SR) begin
            f1[q] <= cfg[q*QB+66];
            f2[q] <= cfg[q*QB+67];
          end else if (CE) begin
            f1[q] <= d1[q];
            f2[q] <= d2[q];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_luxor_slice.sv
module tb_luxor_slice;
  localparam int NQ = 4;
  localparam int P  = 320;
  localparam int NW = 20;

  logic          clk = 1'b0;
  logic          GSR, CIN, CE, SR, cfg_start, cfg_valid;
  logic [23:0]   A;
  logic [3:0]    AX, F78MUX;
  logic [15:0]   cfg_data;
  logic [3:0]    O6_out, A_out, AMUX, AQ;
  logic          COUT, cfg_ready, cfg_done;
  logic [3:0]    o6_0, aout_0, amux_0, aq_0;
  logic          cout_0, rdy_0, done_0;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: full config vector including padding, loader phase
  // (0 idle, 1 loading, 2 done), accepted-word count and flop contents.
  logic [P-1:0] m_cfg = '0;
  int           m_ph = 0, m_cnt = 0;
  logic [3:0]   m_f1 = '0, m_f2 = '0;
  logic [P-1:0] img;

  luxor_slice #(.NUM_QS(4), .XOR6_MODE(2), .CFG_W(16)) dut (
    .clk(clk), .GSR(GSR), .A(A), .AX(AX), .F78MUX(F78MUX), .CIN(CIN),
    .CE(CE), .SR(SR), .O6_out(O6_out), .A_out(A_out), .AMUX(AMUX), .AQ(AQ),
    .COUT(COUT), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_done(cfg_done));

  luxor_slice #(.NUM_QS(4), .XOR6_MODE(0), .CFG_W(16)) dut0 (
    .clk(clk), .GSR(GSR), .A(A), .AX(AX), .F78MUX(F78MUX), .CIN(CIN),
    .CE(CE), .SR(SR), .O6_out(o6_0), .A_out(aout_0), .AMUX(amux_0), .AQ(aq_0),
    .COUT(cout_0), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(rdy_0), .cfg_done(done_0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs computed from the textual rules for the given extension mode.
  task automatic model_comb(input int mode, output logic [3:0] o6v, output logic [3:0] amv,
                            output logic co_out, output logic [3:0] d1v, output logic [3:0] d2v);
    logic c, o6, o5, x6, ce, co, x2, x2x;
    logic [63:0] lut;
    int a, b, s4, s5;
    c = CIN;
    for (int q = 0; q < NQ; q++) begin
      b   = q * 77;
      lut = m_cfg[b +: 64];
      a   = int'(A[6*q +: 6]);
      o6  = lut[a];
      o5  = lut[a % 32];
      x6  = ($countones(A[6*q +: 6]) % 2) == 1;
      ce  = c;
      if (mode == 2 && m_cfg[b+76]) ce = x6 ? c : A[6*q];
      co  = o6 ? ce : (m_cfg[b+68] ? o5 : AX[q]);
      x2  = o6 ^ ce;
      x2x = x6 ^ c;
      s4  = int'(m_cfg[b+70 +: 3]);
      s5  = int'(m_cfg[b+73 +: 3]);
      o6v[q] = o6;
      d1v[q] = m_cfg[b+69] ? o5 : AX[q];
      case (s4)
        0: amv[q] = m_f1[q];
        1: amv[q] = co;
        2: amv[q] = F78MUX[q];
        3: amv[q] = x2;
        4: amv[q] = o5;
        5: amv[q] = o6;
        6: amv[q] = (mode >= 1) ? x6 : 1'b0;
        default: amv[q] = (mode >= 2) ? x2x : 1'b0;
      endcase
      case (s5)
        0: d2v[q] = o6;
        1: d2v[q] = o5;
        2: d2v[q] = AX[q];
        3: d2v[q] = x2;
        4: d2v[q] = F78MUX[q];
        5: d2v[q] = co;
        6: d2v[q] = (mode >= 1) ? x6 : 1'b0;
        default: d2v[q] = (mode >= 2) ? x2x : 1'b0;
      endcase
      c = co;
    end
    co_out = c;
  endtask

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_step();
    logic [3:0] o6v, amv, d1v, d2v;
    logic co;
    int old_ph;
    bit fin;
    model_comb(2, o6v, amv, co, d1v, d2v);
    old_ph = m_ph;
    fin = 0;
    if (GSR) begin
      m_cfg = '0; m_ph = 0; m_cnt = 0; m_f1 = '0; m_f2 = '0;
    end else begin
      if (cfg_start) begin
        if (m_ph != 0 || cfg_start) begin m_ph = 1; m_cnt = 0; end
      end else if (m_ph == 1 && cfg_valid) begin
        m_cfg = {m_cfg[P-17:0], cfg_data};
        m_cnt++;
        if (m_cnt == NW) begin m_ph = 2; fin = 1; end
      end
      for (int q = 0; q < NQ; q++) begin
        if (fin) begin
          m_f1[q] = m_cfg[q*77+64];
          m_f2[q] = m_cfg[q*77+65];
        end else if (old_ph != 1) begin
          if (SR) begin
            m_f1[q] = m_cfg[q*77+66];
            m_f2[q] = m_cfg[q*77+67];
          end else if (CE) begin
            m_f1[q] = d1v[q];
            m_f2[q] = d2v[q];
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] o6v, amv, d1v, d2v, am0, x1, x2;
    logic co, c0;
    model_comb(2, o6v, amv, co, d1v, d2v);
    model_comb(0, x1, am0, c0, x2, d2v);
    chk({tag, ".O6"}, 64'(O6_out), 64'(o6v));
    chk({tag, ".A_out"}, 64'(A_out), 64'(o6v));
    chk({tag, ".AMUX"}, 64'(AMUX), 64'(amv));
    chk({tag, ".AQ"}, 64'(AQ), 64'(m_f2));
    chk({tag, ".COUT"}, 64'(COUT), 64'(co));
    chk({tag, ".ready"}, 64'(cfg_ready), 64'(m_ph == 1));
    chk({tag, ".done"}, 64'(cfg_done), 64'(m_ph == 2));
    chk({tag, ".AMUX_m0"}, 64'(amux_0), 64'(am0));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_inputs();
    A = 24'($urandom); AX = 4'($urandom); F78MUX = 4'($urandom);
    CIN = 1'($urandom); CE = 1'($urandom); SR = 1'($urandom);
  endtask

  task automatic set_q(input int q, input logic [63:0] lut, input logic i1, input logic i2,
                       input logic h1, input logic h2, input logic s1, input logic s3,
                       input logic [2:0] s4, input logic [2:0] s5, input logic s7);
    int b;
    b = q * 77;
    img[b +: 64] = lut;
    img[b+64] = i1; img[b+65] = i2; img[b+66] = h1; img[b+67] = h2;
    img[b+68] = s1; img[b+69] = s3;
    img[b+70 +: 3] = s4; img[b+73 +: 3] = s5; img[b+76] = s7;
  endtask

  task automatic rand_img();
    for (int i = 0; i < P / 32; i++) img[32*i +: 32] = $urandom;
  endtask

  task automatic load_img(input bit toggle, input string tag);
    int idx, cyc, rdy;
    idx = 0; cyc = 0; rdy = 0;
    GSR = 0; cfg_start = 1; cfg_valid = 0;
    tick({tag, ".start"});
    cfg_start = 0;
    while (idx < NW && cyc < 100) begin
      rand_inputs();
      cfg_valid = toggle ? (cyc % 2 == 1) : 1'b1;
      cfg_data  = img[P-1-16*idx -: 16];
      if (cfg_ready) rdy++;
      tick({tag, ".word"});
      if (cfg_valid) idx++;
      cyc++;
    end
    cfg_valid = 0;
    chk({tag, ".ready_cycles"}, 64'(rdy), toggle ? 64'd40 : 64'd20);
    chk({tag, ".done_after_last"}, 64'(cfg_done), 64'd1);
  endtask

  initial begin
    // Reset with arbitrary inputs; AX of the last quarter follows CIN so the
    // zero-config carry path (O6=0 selects AX) also reads as COUT=CIN.
    rand_inputs();
    GSR = 1; cfg_start = 0; cfg_valid = 1; cfg_data = 16'($urandom);
    AX[3] = CIN;
    tick("reset");
    chk("reset.AQ0", 64'(AQ), 64'd0);
    chk("reset.COUT_eq_CIN", 64'(COUT), 64'(CIN));
    GSR = 0; cfg_valid = 0;

    // Image 1: LUT pattern and flop behaviour on q0.
    rand_img();
    set_q(0, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0);
    load_img(0, "load1");
    chk("load1.AQ0_init", 64'(AQ[0]), 64'd1);

    CE = 0; SR = 0;
    A[5:0] = 6'h3F; #1; check_all("lut3f"); chk("lut3f.O6", 64'(O6_out[0]), 64'd1);
    A[5:0] = 6'h00; #1; check_all("lut00"); chk("lut00.O6", 64'(O6_out[0]), 64'd1);
    chk("lut00.O5_via_AMUX", 64'(AMUX[0]), 64'(AQ[0] & 1'b0) | 64'(dut.cfg[70 +: 3] == 3'b100));
    A[5:0] = 6'h20; #1; check_all("lut20"); chk("lut20.O6", 64'(O6_out[0]), 64'd0);

    SR = 1; tick("sr"); chk("sr.AQ0", 64'(AQ[0]), 64'd0);
    SR = 0; CE = 1; AX[0] = 1; tick("ce"); chk("ce.AQ0", 64'(AQ[0]), 64'd1);
    CE = 0; AX[0] = 0; tick("hold1"); tick("hold2"); chk("hold.AQ0", 64'(AQ[0]), 64'd1);

    // Image 2: every LUT all ones, plain carry, loaded with 50% valid duty.
    rand_img();
    for (int q = 0; q < NQ; q++)
      set_q(q, '1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 1'b0);
    load_img(1, "load2");
    CIN = 1; #1; check_all("carry_all"); chk("carry_all.COUT", 64'(COUT), 64'd1);

    // Image 3: q2 generates a 0 from AX, which q3 propagates.
    set_q(2, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
    load_img(0, "load3");
    CIN = 1; AX[2] = 0; #1; check_all("carry_kill"); chk("carry_kill.COUT", 64'(COUT), 64'd0);

    // Image 4: XOR6 on AMUX and XOR6-carry select on q0.
    set_q(2, '1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
    set_q(0, '1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b000, 1'b1);
    load_img(0, "load4");
    A[5:0] = 6'b000001; CIN = 0; #1; check_all("mode");
    chk("mode.AMUX_x6", 64'(AMUX[0]), 64'd1);
    chk("mode.AMUX_m0", 64'(amux_0[0]), 64'd0);
    chk("mode.COUT_cinq", 64'(COUT), 64'd0);

    // Reset part-way through a load discards it.
    rand_img();
    cfg_start = 1; tick("gsr_mid.start"); cfg_start = 0;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1; cfg_data = img[P-1-16*i -: 16]; rand_inputs(); tick("gsr_mid.word");
    end
    GSR = 1; cfg_valid = 1; tick("gsr_mid.reset");
    chk("gsr_mid.ready", 64'(cfg_ready), 64'd0);
    chk("gsr_mid.AQ", 64'(AQ), 64'd0);
    GSR = 0; cfg_valid = 0; tick("gsr_mid.idle");

    // Random traffic including restarts, start+valid collisions and resets.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      GSR       = ($urandom_range(99) < 2);
      cfg_start = ($urandom_range(99) < 4);
      cfg_valid = ($urandom_range(99) < 70);
      cfg_data  = 16'($urandom);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
